// File: rtl/key_event_uart_tx.sv
// -----------------------------------------------------------------------------
// key_event_uart_tx
//
// Queues keyboard/encoder event codes from the keyboard reader and sends each
// one to the host as an 8N1 UART frame on txd, gated by the host's active-low
// clear-to-send line. If a code is lost to a full queue, a unique marker byte
// (0x3F) is sent at the next frame start, ahead of the codes still queued.
//
// Parameters
//   BAUD_DIV  clocks per UART bit (2..65535)
//   FIFO_AW   queue address width, depth = 2**FIFO_AW
//
// Ports
//   clk            keyboard clock, the only clock of this block
//   rst            asynchronous active-high reset
//   keyEventReady  one-cycle strobe qualifying keyEvent
//   keyEvent       event code, [7:6] = 01 press / 10 release / 11 encoder
//   ctsN           host clear-to-send, active low, asynchronous to clk
//   txd            UART serial output, idle high, driven from a flop
//   busy           high while a frame (start bit .. stop bit) is on the wire
//   fifoLevel      number of queued codes, 0 .. 2**FIFO_AW
//   ovfPending     a code was dropped and the marker has not been sent yet
// -----------------------------------------------------------------------------
module key_event_uart_tx #(
    parameter int BAUD_DIV = 35,
    parameter int FIFO_AW  = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               keyEventReady,
    input  logic [7:0]         keyEvent,
    input  logic               ctsN,
    output logic               txd,
    output logic               busy,
    output logic [FIFO_AW:0]   fifoLevel,
    output logic               ovfPending
);

    localparam int                 DEPTH      = 1 << FIFO_AW;
    localparam logic [15:0]        BAUD_LAST  = 16'(BAUD_DIV - 1);
    localparam logic [FIFO_AW:0]   FULL_LEVEL = (FIFO_AW + 1)'(DEPTH);
    localparam logic [7:0]         OVF_MARKER = 8'h3F;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } txStateT;

    // -------------------------------------------------------------------------
    // Clear-to-send synchronizer. Both stages reset to 1 so that nothing is
    // sent until the host has been seen asserting CTS for two clocks.
    // -------------------------------------------------------------------------
    logic ctsMeta;
    logic ctsS;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctsMeta <= 1'b1;
            ctsS    <= 1'b1;
        end else begin
            ctsMeta <= ctsN;
            ctsS    <= ctsMeta;
        end
    end

    // -------------------------------------------------------------------------
    // Event queue
    // -------------------------------------------------------------------------
    logic [7:0]          fifoMem [DEPTH];
    logic [FIFO_AW-1:0]  wrPtrReg;
    logic [FIFO_AW-1:0]  rdPtrReg;
    logic [FIFO_AW:0]    levelReg;
    logic                fifoEmpty;
    logic                fifoFull;
    logic                pushEn;
    logic                popEn;
    logic                dropEn;

    // -------------------------------------------------------------------------
    // Transmitter state
    // -------------------------------------------------------------------------
    txStateT      stateReg;
    txStateT      stateNext;
    logic [15:0]  baudCntReg;
    logic [15:0]  baudCntNext;
    logic [2:0]   bitIdxReg;
    logic [2:0]   bitIdxNext;
    logic [7:0]   shiftReg;
    logic [7:0]   shiftNext;
    logic         txdReg;
    logic         txdNext;
    logic         busyReg;
    logic         busyNext;
    logic         ovfReg;
    logic         bitEnd;
    logic         startFrame;

    assign fifoEmpty = (levelReg == '0);
    assign fifoFull  = (levelReg == FULL_LEVEL);
    assign bitEnd    = (baudCntReg == BAUD_LAST);

    // A frame starts from IDLE when there is something to say and the host
    // allows it. The marker takes precedence and leaves the queue untouched.
    assign startFrame = (stateReg == IDLE) && (!fifoEmpty || ovfReg) && !ctsS;
    assign popEn      = startFrame && !ovfReg;

    // A pop in the same cycle frees the slot the push would otherwise lack.
    assign pushEn = keyEventReady && (!fifoFull || popEn);
    assign dropEn = keyEventReady && fifoFull && !popEn;

    // Storage has no reset: stale contents are unreachable once the pointers
    // and level are cleared.
    always_ff @(posedge clk) begin
        if (pushEn) begin
            fifoMem[wrPtrReg] <= keyEvent;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtrReg <= '0;
            rdPtrReg <= '0;
            levelReg <= '0;
        end else begin
            if (pushEn) begin
                wrPtrReg <= wrPtrReg + FIFO_AW'(1);
            end
            if (popEn) begin
                rdPtrReg <= rdPtrReg + FIFO_AW'(1);
            end
            case ({pushEn, popEn})
                2'b10:   levelReg <= levelReg + (FIFO_AW + 1)'(1);
                2'b01:   levelReg <= levelReg - (FIFO_AW + 1)'(1);
                default: levelReg <= levelReg;
            endcase
        end
    end

    // A drop in the same cycle as the marker leaving re-arms the marker, so
    // the newer loss is reported as well.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovfReg <= 1'b0;
        end else if (dropEn) begin
            ovfReg <= 1'b1;
        end else if (startFrame && ovfReg) begin
            ovfReg <= 1'b0;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stateReg <= IDLE;
        end else begin
            stateReg <= stateNext;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        stateNext = stateReg;
        case (stateReg)
            IDLE: begin
                if (startFrame) begin
                    stateNext = START;
                end
            end
            START: begin
                if (bitEnd) begin
                    stateNext = DATA;
                end
            end
            DATA: begin
                if (bitEnd && (bitIdxReg == 3'd7)) begin
                    stateNext = STOP;
                end
            end
            STOP: begin
                if (bitEnd) begin
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM: output / datapath logic
    // txd and busy are computed from the upcoming state and registered, so the
    // pin changes on the same edge that changes state and never glitches.
    // -------------------------------------------------------------------------
    always_comb begin
        baudCntNext = baudCntReg;
        bitIdxNext  = bitIdxReg;
        shiftNext   = shiftReg;
        txdNext     = 1'b1;
        busyNext    = 1'b0;

        // Counter restarts on every state change and at each bit boundary.
        if (stateReg == IDLE || stateNext != stateReg || bitEnd) begin
            baudCntNext = '0;
        end else begin
            baudCntNext = baudCntReg + 16'd1;
        end

        if (stateReg != DATA) begin
            bitIdxNext = 3'd0;
        end else if (bitEnd) begin
            bitIdxNext = bitIdxReg + 3'd1;
        end

        // The shift register doubles as the registered read port of the queue.
        if (startFrame) begin
            shiftNext = ovfReg ? OVF_MARKER : fifoMem[rdPtrReg];
        end else if (stateReg == DATA && bitEnd) begin
            shiftNext = {1'b0, shiftReg[7:1]};
        end

        case (stateNext)
            START:   txdNext = 1'b0;
            DATA:    txdNext = shiftNext[0];
            default: txdNext = 1'b1;
        endcase

        busyNext = (stateNext != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            baudCntReg <= '0;
            bitIdxReg  <= '0;
            shiftReg   <= '0;
            txdReg     <= 1'b1;
            busyReg    <= 1'b0;
        end else begin
            baudCntReg <= baudCntNext;
            bitIdxReg  <= bitIdxNext;
            shiftReg   <= shiftNext;
            txdReg     <= txdNext;
            busyReg    <= busyNext;
        end
    end

    assign txd        = txdReg;
    assign busy       = busyReg;
    assign fifoLevel  = levelReg;
    assign ovfPending = ovfReg;

endmodule

// File: tb/tb_key_event_uart_tx.sv
// -----------------------------------------------------------------------------
// Bench for key_event_uart_tx with BAUD_DIV = 4 and an 8-deep queue.
// Expected bytes are queued when the stimulus is driven; a serial monitor
// decodes frames from txd, and each scenario task compares what arrived.
// -----------------------------------------------------------------------------
module tb_key_event_uart_tx;

    localparam int BD = 4;
    localparam int AW = 3;
    localparam int FRAME = 10 * BD;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          keyEventReady = 1'b0;
    logic [7:0]    keyEvent = 8'h00;
    logic          ctsN = 1'b0;
    logic          txd;
    logic          busy;
    logic [AW:0]   fifoLevel;
    logic          ovfPending;

    int checks = 0;
    int errors = 0;

    logic [7:0]  expQ[$];
    logic [8:0]  rxQ[$];
    int unsigned rxStart[$];
    int unsigned cycle = 0;

    key_event_uart_tx #(.BAUD_DIV(BD), .FIFO_AW(AW)) dut (
        .clk(clk),
        .rst(rst),
        .keyEventReady(keyEventReady),
        .keyEvent(keyEvent),
        .ctsN(ctsN),
        .txd(txd),
        .busy(busy),
        .fifoLevel(fifoLevel),
        .ovfPending(ovfPending)
    );

    always #5 clk = ~clk;

    // Serial monitor: samples txd at falling edges, decodes 8N1 frames, and
    // records {stop bit, data byte} plus the cycle the start bit was seen.
    initial begin
        bit         inFrame;
        int         mcnt;
        logic [7:0] mbyte;
        logic       prevTxd;
        inFrame = 1'b0;
        mcnt    = 0;
        mbyte   = 8'h00;
        prevTxd = 1'b1;
        forever begin
            @(negedge clk);
            cycle = cycle + 1;
            if (rst) begin
                inFrame = 1'b0;
            end else if (!inFrame) begin
                if (txd === 1'b0 && prevTxd === 1'b1) begin
                    inFrame = 1'b1;
                    mcnt    = 0;
                    rxStart.push_back(cycle);
                end
            end else begin
                mcnt = mcnt + 1;
                if (mcnt >= BD + 2 && mcnt <= 8 * BD + 2 && ((mcnt - BD - 2) % BD) == 0)
                    mbyte[(mcnt - BD - 2) / BD] = txd;
                if (mcnt == 9 * BD + 2)
                    rxQ.push_back({txd, mbyte});
                if (mcnt == FRAME - 1)
                    inFrame = 1'b0;
            end
            prevTxd = txd;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_rx(input int n, input int budget, output bit ok);
        int c;
        c = 0;
        while (rxQ.size() < n && c < budget) begin
            tick();
            c++;
        end
        ok = (rxQ.size() >= n);
    endtask

    task automatic wait_idle();
        int c;
        c = 0;
        while ((busy !== 1'b0 || fifoLevel !== '0) && c < 2000) begin
            tick();
            c++;
        end
        ticks(2);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        ticks(3);
        checks++; if (txd !== 1'b1) begin errors++; $display("FAIL reset_txd got=%b want=1", txd); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
        checks++; if (fifoLevel !== '0) begin errors++; $display("FAIL reset_level got=%0d want=0", fifoLevel); end
        checks++; if (ovfPending !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b want=0", ovfPending); end
        rst = 1'b0;
        ticks(4);
        checks++; if (txd !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL post_reset_idle txd=%b busy=%b want 1/0", txd, busy); end
        $display("test_reset done");
    endtask

    task automatic test_single();
        logic [9:0] fb;
        bit         ok;
        logic [8:0] got;
        logic [7:0] want;
        fb = {1'b1, 8'h45, 1'b0};
        ctsN = 1'b0;
        ticks(4);
        keyEventReady = 1'b1; keyEvent = 8'h45; expQ.push_back(8'h45);
        tick();  // E0
        keyEventReady = 1'b0;
        checks++; if (fifoLevel !== 4'd1) begin errors++; $display("FAIL single_level_e0 got=%0d want=1", fifoLevel); end
        checks++; if (txd !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL single_idle_e0 txd=%b busy=%b want 1/0", txd, busy); end
        for (int k = 0; k < FRAME; k++) begin
            tick();
            if (k == 0) begin
                checks++; if (fifoLevel !== 4'd0) begin errors++; $display("FAIL single_pop_e1 level=%0d want=0", fifoLevel); end
            end
            checks++; if (txd !== fb[k / BD]) begin errors++; $display("FAIL single_txd cyc=%0d got=%b want=%b", k, txd, fb[k / BD]); end
            checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy cyc=%0d got=%b want=1", k, busy); end
        end
        tick();
        checks++; if (busy !== 1'b0 || txd !== 1'b1) begin errors++; $display("FAIL single_end busy=%b txd=%b want 0/1", busy, txd); end
        wait_rx(1, 20, ok);
        checks++; if (!ok) begin errors++; $display("FAIL single_rx_timeout got=%0d frames want=1", rxQ.size()); end
        else begin
            got = rxQ.pop_front(); want = expQ.pop_front();
            checks++; if (got !== {1'b1, want}) begin errors++; $display("FAIL single_byte got=%h want=%h", got, {1'b1, want}); end
        end
        rxStart.delete();
        $display("test_single done");
    endtask

    task automatic test_back_to_back();
        logic [7:0]  codes [3];
        int          peak;
        bit          ok;
        int unsigned st [3];
        logic [8:0]  got;
        logic [7:0]  want;
        codes[0] = 8'h81; codes[1] = 8'hC3; codes[2] = 8'h02;
        wait_idle();
        rxQ.delete(); rxStart.delete();
        peak = 0;
        for (int i = 0; i < 3; i++) begin
            keyEventReady = 1'b1; keyEvent = codes[i]; expQ.push_back(codes[i]);
            tick();
            if (int'(fifoLevel) > peak) peak = int'(fifoLevel);
        end
        keyEventReady = 1'b0;
        for (int i = 0; i < 3 * (FRAME + 1) + 10 && rxQ.size() < 3; i++) begin
            tick();
            if (int'(fifoLevel) > peak) peak = int'(fifoLevel);
        end
        wait_rx(3, 20, ok);
        checks++; if (peak != 2) begin errors++; $display("FAIL b2b_peak got=%0d want=2", peak); end
        checks++; if (!ok || rxStart.size() < 3) begin errors++; $display("FAIL b2b_rx_timeout got=%0d frames want=3", rxQ.size()); end
        else begin
            for (int i = 0; i < 3; i++) begin
                got = rxQ.pop_front(); want = expQ.pop_front(); st[i] = rxStart.pop_front();
                checks++; if (got !== {1'b1, want}) begin errors++; $display("FAIL b2b_byte%0d got=%h want=%h", i, got, {1'b1, want}); end
            end
            checks++; if (st[1] - st[0] != FRAME + 1) begin errors++; $display("FAIL b2b_gap01 got=%0d want=%0d", st[1] - st[0], FRAME + 1); end
            checks++; if (st[2] - st[1] != FRAME + 1) begin errors++; $display("FAIL b2b_gap12 got=%0d want=%0d", st[2] - st[1], FRAME + 1); end
        end
        rxStart.delete();
        $display("test_back_to_back done");
    endtask

    task automatic test_overflow();
        bit         modelOvf;
        int         modelLevel;
        int         c;
        bit         ok;
        logic [8:0] got;
        logic [7:0] want;
        wait_idle();
        rxQ.delete(); rxStart.delete();
        ctsN = 1'b1;
        ticks(4);
        modelOvf = 1'b0; modelLevel = 0;
        for (int i = 0; i < 10; i++) begin
            keyEventReady = 1'b1; keyEvent = 8'h50 + 8'(i);
            if (modelLevel < 8) begin
                expQ.push_back(keyEvent); modelLevel++;
            end else if (!modelOvf) begin
                expQ.push_front(8'h3F); modelOvf = 1'b1;
            end
            tick();
        end
        keyEventReady = 1'b0;
        ticks(3);
        checks++; if (fifoLevel !== 4'd8) begin errors++; $display("FAIL ovf_level got=%0d want=8", fifoLevel); end
        checks++; if (ovfPending !== 1'b1) begin errors++; $display("FAIL ovf_pending got=%b want=1", ovfPending); end
        checks++; if (busy !== 1'b0 || rxStart.size() != 0) begin errors++; $display("FAIL ovf_cts_hold busy=%b starts=%0d want 0/0", busy, rxStart.size()); end
        ctsN = 1'b0;
        c = 0;
        while (busy !== 1'b1 && c < 10) begin tick(); c++; end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ovf_start_timeout busy=%b want=1", busy); end
        checks++; if (ovfPending !== 1'b0) begin errors++; $display("FAIL ovf_clear got=%b want=0", ovfPending); end
        checks++; if (fifoLevel !== 4'd8) begin errors++; $display("FAIL ovf_marker_nopop level=%0d want=8", fifoLevel); end
        wait_rx(9, 9 * (FRAME + 1) + 20, ok);
        checks++; if (!ok) begin errors++; $display("FAIL ovf_rx_timeout got=%0d frames want=9", rxQ.size()); end
        else begin
            for (int i = 0; i < 9; i++) begin
                got = rxQ.pop_front(); want = expQ.pop_front();
                checks++; if (got !== {1'b1, want}) begin errors++; $display("FAIL ovf_byte%0d got=%h want=%h", i, got, {1'b1, want}); end
            end
        end
        rxStart.delete();
        $display("test_overflow done");
    endtask

    task automatic test_push_pop_full();
        bit         ok;
        logic [8:0] got;
        logic [7:0] want;
        wait_idle();
        rxQ.delete(); rxStart.delete();
        ctsN = 1'b1;
        ticks(4);
        for (int i = 0; i < 8; i++) begin
            keyEventReady = 1'b1; keyEvent = 8'h60 + 8'(i); expQ.push_back(keyEvent);
            tick();
        end
        keyEventReady = 1'b0;
        checks++; if (fifoLevel !== 4'd8) begin errors++; $display("FAIL ppf_full got=%0d want=8", fifoLevel); end
        ctsN = 1'b0;
        ticks(2);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ppf_early_start busy=%b want=0", busy); end
        keyEventReady = 1'b1; keyEvent = 8'hFA; expQ.push_back(8'hFA);
        tick();  // edge where the pop happens
        keyEventReady = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ppf_pop_edge busy=%b want=1", busy); end
        checks++; if (fifoLevel !== 4'd8) begin errors++; $display("FAIL ppf_level got=%0d want=8", fifoLevel); end
        checks++; if (ovfPending !== 1'b0) begin errors++; $display("FAIL ppf_ovf got=%b want=0", ovfPending); end
        wait_rx(9, 9 * (FRAME + 1) + 20, ok);
        checks++; if (!ok) begin errors++; $display("FAIL ppf_rx_timeout got=%0d frames want=9", rxQ.size()); end
        else begin
            for (int i = 0; i < 9; i++) begin
                got = rxQ.pop_front(); want = expQ.pop_front();
                checks++; if (got !== {1'b1, want}) begin errors++; $display("FAIL ppf_byte%0d got=%h want=%h", i, got, {1'b1, want}); end
            end
        end
        rxStart.delete();
        $display("test_push_pop_full done");
    endtask

    task automatic test_cts_mid_frame();
        bit         ok;
        int         bad;
        logic [8:0] got;
        logic [7:0] want;
        wait_idle();
        rxQ.delete(); rxStart.delete();
        ctsN = 1'b0;
        keyEventReady = 1'b1; keyEvent = 8'hA1; expQ.push_back(8'hA1); tick();
        keyEvent = 8'hB2; expQ.push_back(8'hB2); tick();
        keyEventReady = 1'b0;
        ticks(12);
        ctsN = 1'b1;
        wait_rx(1, FRAME + 10, ok);
        checks++; if (!ok) begin errors++; $display("FAIL cts_rx1_timeout got=%0d frames want=1", rxQ.size()); end
        else begin
            got = rxQ.pop_front(); want = expQ.pop_front();
            checks++; if (got !== {1'b1, want}) begin errors++; $display("FAIL cts_byte0 got=%h want=%h", got, {1'b1, want}); end
        end
        ticks(3);
        bad = 0;
        for (int i = 0; i < 80; i++) begin
            tick();
            if (busy !== 1'b0 || txd !== 1'b1) bad++;
        end
        checks++; if (bad != 0 || rxQ.size() != 0) begin errors++; $display("FAIL cts_hold bad_cycles=%0d frames=%0d want 0/0", bad, rxQ.size()); end
        checks++; if (fifoLevel !== 4'd1) begin errors++; $display("FAIL cts_hold_level got=%0d want=1", fifoLevel); end
        ctsN = 1'b0;
        wait_rx(1, FRAME + 20, ok);
        checks++; if (!ok) begin errors++; $display("FAIL cts_rx2_timeout got=%0d frames want=1", rxQ.size()); end
        else begin
            got = rxQ.pop_front(); want = expQ.pop_front();
            checks++; if (got !== {1'b1, want}) begin errors++; $display("FAIL cts_byte1 got=%h want=%h", got, {1'b1, want}); end
        end
        rxStart.delete();
        $display("test_cts_mid_frame done");
    endtask

    task automatic test_reset_mid_frame();
        bit         ok;
        int         bad;
        logic [8:0] got;
        logic [7:0] want;
        wait_idle();
        rxQ.delete(); rxStart.delete();
        ctsN = 1'b0;
        keyEventReady = 1'b1; keyEvent = 8'hC5; expQ.push_back(8'hC5); tick();
        keyEvent = 8'hD6; expQ.push_back(8'hD6); tick();
        keyEventReady = 1'b0;
        ticks(16);  // now inside data bit 3 of the first frame
        #2;
        rst = 1'b1;
        #1;
        checks++; if (txd !== 1'b1) begin errors++; $display("FAIL rstmid_txd got=%b want=1", txd); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got=%b want=0", busy); end
        checks++; if (fifoLevel !== '0) begin errors++; $display("FAIL rstmid_level got=%0d want=0", fifoLevel); end
        expQ.delete();
        ticks(2);
        rst = 1'b0;
        rxQ.delete(); rxStart.delete();
        bad = 0;
        for (int i = 0; i < 80; i++) begin
            tick();
            if (busy !== 1'b0 || txd !== 1'b1) bad++;
        end
        checks++; if (bad != 0 || rxStart.size() != 0) begin errors++; $display("FAIL rstmid_quiet bad_cycles=%0d starts=%0d want 0/0", bad, rxStart.size()); end
        keyEventReady = 1'b1; keyEvent = 8'hE7; expQ.push_back(8'hE7); tick();
        keyEventReady = 1'b0;
        wait_rx(1, FRAME + 20, ok);
        checks++; if (!ok) begin errors++; $display("FAIL rstmid_rx_timeout got=%0d frames want=1", rxQ.size()); end
        else begin
            got = rxQ.pop_front(); want = expQ.pop_front();
            checks++; if (got !== {1'b1, want}) begin errors++; $display("FAIL rstmid_byte got=%h want=%h", got, {1'b1, want}); end
        end
        rxStart.delete();
        $display("test_reset_mid_frame done");
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_push_pop_full();
        test_cts_mid_frame();
        test_reset_mid_frame();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
